// File: rtl/counter_job_sched.sv
// counter_job_sched: round-robin scheduler for two requesters sharing one
// up/down counter. Each job loads a start value, counts a number of steps
// in a chosen direction, and reports the final count with a self-check flag.
module counter_job_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_start,
    input  logic [WIDTH-1:0] req0_steps,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_start,
    input  logic [WIDTH-1:0] req1_steps,
    input  logic             req1_dir,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_id,
    output logic [WIDTH-1:0] done_value,
    output logic             done_err,
    output logic             busy,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic [WIDTH-1:0] cnt_din,
    input  logic [WIDTH-1:0] cnt_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;       // last granted requester
    logic             id_q, id_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // count edges still to go
    logic [WIDTH-1:0] exp_q, exp_d;       // value the counter should end on

    logic             grant0, grant1, accept;
    logic [WIDTH-1:0] sel_start, sel_steps;
    logic             sel_dir;

    // Round-robin grant: the requester that did not win last time has priority.
    always_comb begin
        grant0 = (state_q == S_IDLE) && req0_valid && (!req1_valid || ptr_q);
        grant1 = (state_q == S_IDLE) && req1_valid && (!req0_valid || !ptr_q);
        accept = grant0 || grant1;
        sel_start = grant1 ? req1_start : req0_start;
        sel_steps = grant1 ? req1_steps : req0_steps;
        sel_dir   = grant1 ? req1_dir   : req0_dir;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state and capture logic for the job FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dir_d   = dir_q;
        start_d = start_q;
        rem_d   = rem_q;
        exp_d   = exp_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ptr_d   = grant1;
                    id_d    = grant1;
                    dir_d   = sel_dir;
                    start_d = sel_start;
                    rem_d   = sel_steps;
                    // Wraps modulo 2^WIDTH exactly like the counter does.
                    exp_d   = sel_dir ? (sel_start - sel_steps) : (sel_start + sel_steps);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (rem_q != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                rem_d = rem_q - WIDTH'(1);
                if (rem_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured job registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            id_q    <= 1'b0;
            dir_q   <= 1'b0;
            start_q <= '0;
            rem_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dir_q   <= dir_d;
            start_q <= start_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
        end
    end

    // Counter controls and result outputs decoded from state.
    always_comb begin
        busy       = (state_q != S_IDLE);
        cnt_load   = (state_q == S_LOAD);
        cnt_en     = (state_q == S_LOAD) || (state_q == S_RUN);
        cnt_mode   = cnt_en && dir_q;
        cnt_din    = cnt_load ? start_q : '0;
        done_valid = (state_q == S_DONE);
        done_id    = id_q;
        done_value = done_valid ? cnt_q : '0;
        done_err   = done_valid && (cnt_q != exp_q);
    end

endmodule
